alif_neuron_array: RTL and testbench

//  N adaptive leaky integrate-and-fire neurons. They share one datapath that is

---
 rtl/alif_neuron_array.sv | 212 +++++++++++++++++++++
 tb/tb_alif_neuron_array.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alif_neuron_array.sv
// Array of adaptive leaky integrate-and-fire neurons sharing one time-multiplexed
// datapath; each tick sweeps all neurons once and spikes are queued in an event FIFO.
module alif_neuron_array #(
  parameter int N_NEURONS   = 8,
  parameter int W           = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADAPT_SHIFT = 2,
  parameter int RFR_W       = 4,
  parameter int THR_RST     = 200,
  parameter int STEP_RST    = 40,
  localparam int IDX_W      = $clog2(N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [N_NEURONS*W-1:0] in_current,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [W-1:0]           cfg_wdata,
  output logic                   busy,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [IDX_W-1:0]       ev_idx,
  output logic                   ovf,
  output logic                   overrun,
  input  logic [IDX_W-1:0]       mon_idx,
  output logic [W-1:0]           mon_vmem,
  output logic [W-1:0]           mon_adapt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_NEURONS - 1);
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;
  state_t state;
  logic [IDX_W-1:0] k;

  logic [W-1:0]     cfg_thr, cfg_step, cfg_leak, cfg_decay;
  logic [RFR_W-1:0] cfg_refrac;
  logic [W-1:0]     sh_thr, sh_step, sh_leak, sh_decay;
  logic [RFR_W-1:0] sh_refrac;

  logic [W-1:0]     v_mem     [N_NEURONS];
  logic [W-1:0]     adapt_mem [N_NEURONS];
  logic [RFR_W-1:0] rfr_mem   [N_NEURONS];

  // Datapath for the neuron selected by k
  logic [W-1:0]        v_cur, a_cur, i_cur, a_frac, a_decay, a_sat, v_sat;
  logic [RFR_W-1:0]    r_cur;
  logic [W:0]          a_sum;
  logic signed [W+1:0] v_sum;
  logic [W-1:0]        v_nxt, a_nxt;
  logic [RFR_W-1:0]    r_nxt;
  logic                spike;

  assign v_cur  = v_mem[k];
  assign a_cur  = adapt_mem[k];
  assign r_cur  = rfr_mem[k];
  assign i_cur  = in_current[k*W +: W];
  assign a_frac = a_cur >> ADAPT_SHIFT;

  always_comb begin
    a_decay = (a_cur > sh_decay) ? a_cur - sh_decay : '0;
    a_sum   = {1'b0, a_cur} + {1'b0, sh_step};
    a_sat   = a_sum[W] ? '1 : a_sum[W-1:0];
    v_sum   = $signed({2'b00, v_cur}) + $signed({2'b00, i_cur})
            - $signed({2'b00, sh_leak}) - $signed({2'b00, a_frac});
    // Range is [-318, 510] for W=8, so bit W flags overflow once the sign is clear
    if (v_sum[W+1])  v_sat = '0;
    else if (v_sum[W]) v_sat = '1;
    else             v_sat = v_sum[W-1:0];

    v_nxt = v_sat;
    a_nxt = a_decay;
    r_nxt = r_cur;
    spike = 1'b0;
    if (r_cur != '0) begin
      v_nxt = '0;
      r_nxt = r_cur - 1'b1;
    end else if (v_cur >= sh_thr) begin
      spike = 1'b1;
      v_nxt = '0;
      a_nxt = a_sat;
      r_nxt = sh_refrac;
    end
  end

  assign busy = (state == S_SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      sh_thr    <= W'(THR_RST);
      sh_step   <= W'(STEP_RST);
      sh_leak   <= '0;
      sh_decay  <= '0;
      sh_refrac <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n]     <= '0;
        adapt_mem[n] <= '0;
        rfr_mem[n]   <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_SWEEP;
            k         <= '0;
            sh_thr    <= cfg_thr;
            sh_step   <= cfg_step;
            sh_leak   <= cfg_leak;
            sh_decay  <= cfg_decay;
            sh_refrac <= cfg_refrac;
          end
        end
        S_SWEEP: begin
          v_mem[k]     <= v_nxt;
          adapt_mem[k] <= a_nxt;
          rfr_mem[k]   <= r_nxt;
          if (k == K_LAST) begin
            state <= S_IDLE;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Live configuration; the sweep only ever sees the shadow copies
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_thr    <= W'(THR_RST);
      cfg_step   <= W'(STEP_RST);
      cfg_leak   <= '0;
      cfg_decay  <= '0;
      cfg_refrac <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    cfg_thr    <= cfg_wdata;
        3'd1:    cfg_step   <= cfg_wdata;
        3'd2:    cfg_leak   <= cfg_wdata;
        3'd3:    cfg_decay  <= cfg_wdata;
        3'd4:    cfg_refrac <= cfg_wdata[RFR_W-1:0];
        default: ;
      endcase
    end
  end

  // Event FIFO. Handshake: an event transfers on any cycle where ev_valid && ev_ready;
  // ev_valid never drops and ev_idx never changes until that transfer happens.
  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]      count, cnt_after_pop;
  logic             push_req, pop, full, push, drop, clr_flags;

  assign ev_valid      = (count != '0);
  assign pop           = ev_valid && ev_ready;
  assign full          = (count == FULL_CNT);
  assign push_req      = (state == S_SWEEP) && spike;
  assign push          = push_req && (!full || pop);
  assign drop          = push_req && full && !pop;
  assign cnt_after_pop = count - (PW + 1)'(pop);
  assign rd_nxt        = rd_ptr + 1'b1;
  assign clr_flags     = cfg_we && (cfg_addr == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ev_idx <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= k;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_nxt;
      count <= cnt_after_pop + (PW + 1)'(push);
      // ev_idx mirrors the head entry and keeps its last value once the FIFO drains
      if (push && cnt_after_pop == '0)
        ev_idx <= k;
      else if (pop && cnt_after_pop != '0)
        ev_idx <= fifo_mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ovf     <= (ovf && !clr_flags) || drop;
      overrun <= (overrun && !clr_flags) || (tick && state == S_SWEEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_vmem  <= '0;
      mon_adapt <= '0;
    end else if (int'(mon_idx) < N_NEURONS) begin
      mon_vmem  <= v_mem[mon_idx];
      mon_adapt <= adapt_mem[mon_idx];
    end
  end

endmodule

// File: tb/tb_alif_neuron_array.sv
// Bench for alif_neuron_array: table of per-sweep vectors plus directed sequences for
// FIFO overflow, overrun/shadowing and mid-sweep reset; events checked via exp_q.
module tb_alif_neuron_array;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst, tick, cfg_we, ev_ready;
  logic [N*W-1:0]   in_current;
  logic [2:0]       cfg_addr;
  logic [W-1:0]     cfg_wdata;
  logic             busy, ev_valid, ovf, overrun;
  logic [IDX_W-1:0] ev_idx, mon_idx;
  logic [W-1:0]     mon_vmem, mon_adapt;

  alif_neuron_array dut (
    .clk(clk), .rst(rst), .tick(tick), .in_current(in_current),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx),
    .ovf(ovf), .overrun(overrun), .mon_idx(mon_idx),
    .mon_vmem(mon_vmem), .mon_adapt(mon_adapt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard: every accepted event must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_event: got idx %0d expected none", ev_idx);
      end else begin
        check("ev_idx", ev_idx, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic reset_dut();
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ev_ready = 1'b0; in_current = '0; mon_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_i(input int k, input logic [W-1:0] val);
    in_current[k*W +: W] = val;
  endtask

  task automatic tick_pulse();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic run_sweep();
    int n;
    tick_pulse();
    n = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_len", n, N);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!ev_valid) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("drain_done", ev_valid, 0);
    check("exp_q_left", exp_q.size(), 0);
  endtask

  task automatic read_mon(input int idx, output logic [W-1:0] v, output logic [W-1:0] a);
    @(posedge clk); #1 mon_idx = IDX_W'(idx);
    @(posedge clk); #1;
    v = mon_vmem;
    a = mon_adapt;
  endtask

  typedef struct {
    logic [W-1:0] i0, i5;
    logic         sp0, sp5;
    logic [W-1:0] v0, a0, v5, a5;
  } vec_t;
  vec_t tv[16];

  task automatic apply_vectors(input int first, input int last);
    logic [W-1:0] v, a;
    for (int i = first; i <= last; i++) begin
      in_current = '0;
      set_i(0, tv[i].i0);
      set_i(5, tv[i].i5);
      if (tv[i].sp0) exp_q.push_back(IDX_W'(0));
      if (tv[i].sp5) exp_q.push_back(IDX_W'(5));
      run_sweep();
      drain();
      read_mon(0, v, a);
      check($sformatf("v0_vec%0d", i), v, tv[i].v0);
      check($sformatf("a0_vec%0d", i), a, tv[i].a0);
      read_mon(5, v, a);
      check($sformatf("v5_vec%0d", i), v, tv[i].v5);
      check($sformatf("a5_vec%0d", i), a, tv[i].a5);
    end
  endtask

  initial begin
    logic [W-1:0] v, a;
    int n;

    // Integration/saturation/adaptation with default config (thr=200, step=40)
    tv[0]  = '{i0:60, i5:100, sp0:0, sp5:0, v0:60,  a0:0,  v5:100, a5:0};
    tv[1]  = '{i0:60, i5:100, sp0:0, sp5:0, v0:120, a0:0,  v5:200, a5:0};
    tv[2]  = '{i0:60, i5:100, sp0:0, sp5:1, v0:180, a0:0,  v5:0,   a5:40};
    tv[3]  = '{i0:60, i5:100, sp0:0, sp5:0, v0:240, a0:0,  v5:90,  a5:40};
    tv[4]  = '{i0:60, i5:100, sp0:1, sp5:0, v0:0,   a0:40, v5:180, a5:40};
    tv[5]  = '{i0:60, i5:100, sp0:0, sp5:0, v0:50,  a0:40, v5:255, a5:40};
    tv[6]  = '{i0:60, i5:100, sp0:0, sp5:1, v0:100, a0:40, v5:0,   a5:80};
    // Refractory = 2, decay = 5
    tv[7]  = '{i0:60, i5:0, sp0:0, sp5:0, v0:60,  a0:0,  v5:0, a5:0};
    tv[8]  = '{i0:60, i5:0, sp0:0, sp5:0, v0:120, a0:0,  v5:0, a5:0};
    tv[9]  = '{i0:60, i5:0, sp0:0, sp5:0, v0:180, a0:0,  v5:0, a5:0};
    tv[10] = '{i0:60, i5:0, sp0:0, sp5:0, v0:240, a0:0,  v5:0, a5:0};
    tv[11] = '{i0:60, i5:0, sp0:1, sp5:0, v0:0,   a0:40, v5:0, a5:0};
    tv[12] = '{i0:60, i5:0, sp0:0, sp5:0, v0:0,   a0:35, v5:0, a5:0};
    tv[13] = '{i0:60, i5:0, sp0:0, sp5:0, v0:0,   a0:30, v5:0, a5:0};
    tv[14] = '{i0:60, i5:0, sp0:0, sp5:0, v0:53,  a0:25, v5:0, a5:0};
    tv[15] = '{i0:60, i5:0, sp0:0, sp5:0, v0:107, a0:20, v5:0, a5:0};

    // Reset state, then an idle sweep with zero input
    reset_dut();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_idx", ev_idx, 0);
    check("rst_ovf", ovf, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mon_vmem", mon_vmem, 0);
    check("rst_mon_adapt", mon_adapt, 0);
    ev_ready = 1'b1;
    run_sweep();
    drain();
    read_mon(0, v, a);
    check("t1_v0", v, 0);
    read_mon(7, v, a);
    check("t1_v7", v, 0);

    // Table: integrate, spike, adapt, saturate
    reset_dut();
    ev_ready = 1'b1;
    apply_vectors(0, 6);

    // Table: refractory hold and adaptation decay
    reset_dut();
    ev_ready = 1'b1;
    cfg_write(3'd3, 8'd5);
    cfg_write(3'd4, 8'd2);
    apply_vectors(7, 15);

    // FIFO overflow, full-with-pop acceptance, stable head, flag clear
    reset_dut();
    for (int k = 0; k < N; k++) set_i(k, 8'd255);
    run_sweep();
    check("t4_no_event", ev_valid, 0);
    in_current = '0;
    for (int k = 0; k < 5; k++) exp_q.push_back(IDX_W'(k));
    tick_pulse();
    repeat (4) @(posedge clk);
    #1 ev_ready = 1'b1;
    @(posedge clk); #1 ev_ready = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("t4_sweep_end", busy, 0);
    check("t4_ovf", ovf, 1);
    check("t4_ev_valid", ev_valid, 1);
    check("t4_head", ev_idx, 1);
    repeat (3) @(negedge clk);
    check("t4_head_stable", ev_idx, 1);
    ev_ready = 1'b1;
    drain();
    check("t4_ovf_sticky", ovf, 1);
    check("t4_idx_hold", ev_idx, 4);
    cfg_write(3'd7, 8'd0);
    @(negedge clk);
    check("t4_ovf_clr", ovf, 0);

    // Overrun and config shadowing
    reset_dut();
    ev_ready = 1'b1;
    set_i(5, 8'd100);
    run_sweep();
    tick_pulse();
    n = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
      if (n == 2) begin
        tick = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'd50;
      end else if (n == 3) begin
        tick = 1'b0; cfg_we = 1'b0;
      end
    end
    check("t5_busy_len", n, N);
    check("t5_overrun", overrun, 1);
    read_mon(5, v, a);
    check("t5_v5_shadow", v, 200);
    check("t5_no_event", exp_q.size(), 0);
    exp_q.push_back(IDX_W'(5));
    run_sweep();
    drain();
    read_mon(5, v, a);
    check("t5_v5_spiked", v, 0);
    check("t5_ovf", ovf, 0);
    cfg_write(3'd7, 8'd0);
    @(negedge clk);
    check("t5_overrun_clr", overrun, 0);

    // Reset in sweep cycle 3
    ev_ready = 1'b0;
    for (int k = 0; k < N; k++) set_i(k, 8'd30);
    tick_pulse();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_ev_valid", ev_valid, 0);
    check("t6_ev_idx", ev_idx, 0);
    check("t6_overrun", overrun, 0);
    check("t6_ovf", ovf, 0);
    for (int k = 0; k < N; k++) begin
      read_mon(k, v, a);
      check($sformatf("t6_v%0d", k), v, 0);
      check($sformatf("t6_a%0d", k), a, 0);
    end
    ev_ready = 1'b1;
    in_current = '0;
    set_i(0, 8'd150);
    run_sweep();
    run_sweep();
    drain();
    read_mon(0, v, a);
    check("t6_cfg_thr_rst", v, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
